// File: rtl/div_sequencer.sv
// ---------------------------------------------------------------------------
// div_sequencer
//   Multi-cycle signed divide controller for the ALU DIV operation.
//   Runs a radix-2 restoring division on operand magnitudes, then applies the
//   sign correction. The quotient feeds LO and the remainder feeds HI.
//
// Ports
//   clock        in   system clock, rising-edge active
//   clear        in   asynchronous active-low reset
//   start        in   division request, sampled only in IDLE
//   dividend     in   WIDTH  two's-complement dividend (sampled on start edge)
//   divisor      in   WIDTH  two's-complement divisor  (sampled on start edge)
//   busy         out  high while iterating (CALC) or sign-fixing (FIX)
//   done         out  one-cycle completion pulse
//   div_by_zero  out  last completed operation had divisor == 0
//   quotient     out  WIDTH  registered signed quotient (LO)
//   remainder    out  WIDTH  registered signed remainder (HI)
//   dbg_state    out  2      current FSM state (IDLE=0, CALC=1, FIX=2, DONE=3)
//
// Handshake: a request is accepted on any rising edge where the FSM is IDLE
// and start is high; operands are captured on that edge only. From then on
// start is ignored (no queuing) until the FSM returns to IDLE. busy stays high
// through CALC and FIX, done is high for exactly the single DONE cycle, and
// quotient/remainder/div_by_zero hold their values until the next result is
// written.
// ---------------------------------------------------------------------------
module div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;

    // Partial remainder A. After every restoring step A < M, so the stored
    // value always fits in WIDTH bits; the extra bit only lives in the
    // shifted/subtracted path below.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;

    logic             w_dv_zero;
    logic [WIDTH-1:0] w_abs_dd;
    logic [WIDTH-1:0] w_abs_dv;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_neg;

    assign w_dv_zero = (divisor == '0);

    // Magnitudes are taken as unsigned, so the most negative value maps to
    // 2^(WIDTH-1) without overflow.
    assign w_abs_dd = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign w_abs_dv = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;

    // One restoring step: shift {A,Q} left, trial-subtract M.
    assign w_shift = {r_a, r_q[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_m};
    assign w_neg   = w_diff[WIDTH];

    // ---------------- FSM state register ----------------
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM next state / outputs ----------------
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_dv_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (r_cnt == LAST_ITER) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_a      <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_dbz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_dv_zero) begin
                            // Result is fixed directly; no iterations run.
                            r_quot <= '1;
                            r_rem  <= dividend;
                            r_dbz  <= 1'b1;
                        end else begin
                            r_q      <= w_abs_dd;
                            r_m      <= w_abs_dv;
                            r_a      <= '0;
                            r_cnt    <= '0;
                            r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            r_sign_r <= dividend[WIDTH-1];
                        end
                    end
                end
                S_CALC: begin
                    r_a   <= w_neg ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                    r_q   <= {r_q[WIDTH-2:0], ~w_neg};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    // Quotient truncates toward zero; remainder follows the
                    // dividend's sign. -2^31 / -1 wraps naturally here.
                    r_quot <= r_sign_q ? (~r_q + 1'b1) : r_q;
                    r_rem  <= r_sign_r ? (~r_a + 1'b1) : r_a;
                    r_dbz  <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;
    assign dbg_state   = r_state;

endmodule
